acc_feeder: RTL and testbench
=============================

ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 SHALL have parameter IN_DATA_WIDTH, default 8, meaning width of each data element.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning width of the frame-length field.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two), meaning number of input buffer entries.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port start_i, input, 1, single-cycle frame start request.
REQ-007 SHALL have port len_i, input, LEN_WIDTH, number of elements in the frame, sampled with start_i.
REQ-008 SHALL have port s_valid_i, input, 1, upstream element valid.
REQ-009 SHALL have port s_data_i, input, IN_DATA_WIDTH, upstream element.
REQ-010 SHALL have port s_ready_o, output, 1, buffer can accept an element.
REQ-011 SHALL have port number_o, output, IN_DATA_WIDTH, element to the accumulator core.
REQ-012 SHALL have port valid_o, output, 1, number_o is valid this cycle.
REQ-013 SHALL have port run_o, output, 1, accumulator run enable.
REQ-014 SHALL have port busy_o, output, 1, a frame is in progress.
REQ-015 SHALL have port done_o, output, 1, single-cycle frame-complete pulse.

Function
REQ-016 SHALL accept an upstream element on any cycle where s_valid_i and s_ready_o are both high, in every FSM state.
REQ-017 SHALL drive s_ready_o high exactly when the buffer is not full; a push and a pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-018 SHALL implement the states IDLE, RUN, FLUSH and DONE.
REQ-019 In IDLE, start_i with len_i nonzero SHALL load the remaining count with len_i and enter RUN.
REQ-020 In IDLE, start_i with len_i zero SHALL enter DONE directly, with no run_o assertion.
REQ-021 In RUN, with the buffer non-empty, the block SHALL pop one element per cycle and decrement the remaining count.
REQ-022 number_o and valid_o SHALL be registered, appearing 1 cycle after the pop.
REQ-023 In RUN, with the buffer empty, the block SHALL stall: no pop, and valid_o low the next cycle.
REQ-024 The pop that brings the remaining count to zero SHALL move the FSM to FLUSH.
REQ-025 FLUSH SHALL last 1 cycle, with run_o high and valid_o carrying the last element, then move to DONE.
REQ-026 DONE SHALL last 1 cycle with done_o high, then return to IDLE.
REQ-027 run_o SHALL be high in RUN and FLUSH only, and busy_o SHALL be high in RUN, FLUSH and DONE.
REQ-028 start_i SHALL be ignored outside IDLE.
REQ-029 Elements arriving beyond the frame length SHALL stay buffered for the next frame.
REQ-030 number_o SHALL hold its last value while valid_o is low.

Reset
REQ-031 While reset is high, the FSM SHALL be in IDLE, the buffer empty and the count zero.
REQ-032 While reset is high, number_o SHALL be 0; valid_o, run_o, busy_o and done_o SHALL be 0; and s_ready_o SHALL be 1.
REQ-033 Reset asserted mid-frame SHALL abort the frame and discard buffered data, with no done_o pulse.

Configuration
REQ-034 With macro ACC_FEEDER_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o, 16 bits, cleared on frame start, incrementing on each RUN cycle with an empty buffer, and saturating at 16'hFFFF.
REQ-035 Without ACC_FEEDER_STALL_CNT_EN, the block SHALL have no stall_cnt_o port and no stall counter logic.

Structure
REQ-036 Package acc_pkg SHALL hold the FSM state typedef (IDLE/RUN/FLUSH/DONE) and the default width constants shared with the accumulator core.
REQ-037 The buffer SHALL be the sub-module acc_fifo: synchronous, showahead, with full/empty flags and a pointer wrap using an extra MSB.

Verification
REQ-038 Verification SHALL cover: 4 elements 1..4 pre-buffered, start_i with len_i=4 -> valid_o on 4 consecutive cycles with number_o 1,2,3,4, run_o high for 5 cycles, done_o 1 cycle later.
REQ-039 Verification SHALL cover: start_i with len_i=3 and an empty buffer, elements then pushed with 2-cycle gaps -> valid_o with gaps and the order preserved; stall_cnt_o=4 when the macro is on.
REQ-040 Verification SHALL cover: start_i with len_i=0 -> done_o on the next cycle and run_o never high.
REQ-041 Verification SHALL cover: 5 pushes into an idle buffer with FIFO_DEPTH=4 -> s_ready_o low after the 4th push and the 5th held by upstream; then len_i=2 -> 2 elements consumed and 3 remaining buffered.
REQ-042 Verification SHALL cover: reset asserted during RUN of a len_i=100 frame -> all outputs at reset values asynchronously and no done_o.
REQ-043 Verification SHALL cover: start_i pulsed during RUN -> ignored, with the frame length unchanged.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: FSM state type and default widths shared by the accumulator feeder
// and the accumulator core.
package acc_pkg;
  localparam int ACC_DATA_W     = 8;
  localparam int ACC_LEN_W      = 8;
  localparam int ACC_FIFO_DEPTH = 4;
  localparam int STALL_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } acc_state_e;
endpackage

// File: rtl/acc_fifo.sv
// acc_fifo: synchronous showahead buffer. The pointers carry one extra MSB so
// that full and empty can be told apart when the index bits match.
module acc_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;

  // Pointer update; push and pop in one cycle both advance
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/acc_feeder.sv
// acc_feeder: buffers upstream elements and streams one frame of len_i
// elements into the accumulator core (IDLE -> RUN -> FLUSH -> DONE).
// Optional: define ACC_FEEDER_STALL_CNT_EN to add stall_cnt_o, a saturating
// count of RUN cycles spent waiting on an empty buffer.
module acc_feeder
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = ACC_DATA_W,
  parameter int LEN_WIDTH     = ACC_LEN_W,
  parameter int FIFO_DEPTH    = ACC_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic [IN_DATA_WIDTH-1:0] number_o,
  output logic                     valid_o,
  output logic                     run_o,
  output logic                     busy_o,
`ifdef ACC_FEEDER_STALL_CNT_EN
  output logic                     done_o,
  output logic [STALL_CNT_W-1:0]   stall_cnt_o
`else
  output logic                     done_o
`endif
);
  acc_state_e               state, state_nxt;
  logic [LEN_WIDTH-1:0]     cnt, cnt_nxt;
  logic                     pop;
  logic                     fifo_full, fifo_empty;
  logic [IN_DATA_WIDTH-1:0] fifo_data;

  acc_fifo #(
    .DATA_W (IN_DATA_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid_i),
    .push_data (s_data_i),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Upstream is accepted whenever there is room, regardless of FSM state
  assign s_ready_o = !fifo_full;

  // Next state, remaining count, pop and status outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    run_o     = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cnt_nxt   = len_i;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RUN: begin
        run_o  = 1'b1;
        busy_o = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_nxt = cnt - 1'b1;
          if (cnt == LEN_WIDTH'(1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        run_o     = 1'b1;
        busy_o    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, count and the registered element stage; number_o holds when idle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      valid_o  <= 1'b0;
      number_o <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      valid_o <= pop;
      if (pop) number_o <= fifo_data;
    end

`ifdef ACC_FEEDER_STALL_CNT_EN
  // Starved RUN cycles, restarted by every accepted start, saturating
  always_ff @(posedge clk or posedge reset)
    if (reset)
      stall_cnt_o <= '0;
    else if (state == IDLE && start_i)
      stall_cnt_o <= '0;
    else if (state == RUN && fifo_empty && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + 1'b1;
`endif
endmodule

// File: tb/tb_acc_feeder.sv
// tb_acc_feeder: directed frame scenarios plus randomized frames checked
// against a queue model of the buffer and frame-level expectations.
module tb_acc_feeder;
  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic [DW-1:0] number_o;
  logic          valid_o, run_o, busy_o, done_o;
`ifdef ACC_FEEDER_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model of buffer contents: elements accepted but not yet seen on number_o
  logic [DW-1:0] mq [$];

  always #5 clk = ~clk;

  acc_feeder #(.IN_DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .len_i       (len_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .number_o    (number_o),
    .valid_o     (valid_o),
    .run_o       (run_o),
    .busy_o      (busy_o),
`ifdef ACC_FEEDER_STALL_CNT_EN
    .done_o      (done_o),
    .stall_cnt_o (stall_cnt_o)
`else
    .done_o      (done_o)
`endif
  );

  // Handshake observer feeding the model queue
  always @(posedge clk or posedge reset)
    if (reset) mq.delete();
    else if (s_valid_i && s_ready_o) mq.push_back(s_data_i);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start_i = 1'b0; s_valid_i = 1'b0; len_i = '0; s_data_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] act;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    act = {number_o, valid_o, run_o, busy_o, done_o, s_ready_o};
    n_cmp++;
    if (act !== {8'h00, 5'b00001}) begin
      n_err++; $display("FAIL reset_async: got num/v/run/busy/done/rdy=%h expected %h", act, {8'h00, 5'b00001});
    end
    repeat (2) @(posedge clk);
    #1;
    act = {number_o, valid_o, run_o, busy_o, done_o, s_ready_o};
    n_cmp++;
    if (act !== {8'h00, 5'b00001}) begin
      n_err++; $display("FAIL reset_held: got %h expected %h", act, {8'h00, 5'b00001});
    end
`ifdef ACC_FEEDER_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_prebuffered();
    logic [11:0] exp_t [7];
    logic [11:0] act;
    // {valid, number, run, busy, done}
    exp_t = '{ {1'b0, 8'd0, 3'b110}, {1'b1, 8'd1, 3'b110}, {1'b1, 8'd2, 3'b110}, {1'b1, 8'd3, 3'b110},
               {1'b1, 8'd4, 3'b110}, {1'b0, 8'd4, 3'b011}, {1'b0, 8'd4, 3'b000} };
    apply_reset();
    for (int i = 1; i <= 4; i++) begin s_valid_i = 1'b1; s_data_i = 8'(i); tick(); end
    s_valid_i = 1'b0; start_i = 1'b1; len_i = 8'd4; tick(); start_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      act = {valid_o, number_o, run_o, busy_o, done_o};
      n_cmp++;
      if (act !== exp_t[k]) begin
        n_err++; $display("FAIL prebuf_t%0d: got v/num/run/busy/done=%h expected %h", k, act, exp_t[k]);
      end
      tick();
    end
  endtask

  task automatic test_gaps();
    logic [11:0] exp_t [10];
    logic [11:0] act;
    exp_t = '{ {1'b0, 8'h00, 3'b110}, {1'b1, 8'hA1, 3'b110}, {1'b0, 8'hA1, 3'b110}, {1'b0, 8'hA1, 3'b110},
               {1'b1, 8'hB2, 3'b110}, {1'b0, 8'hB2, 3'b110}, {1'b0, 8'hB2, 3'b110}, {1'b1, 8'hC3, 3'b110},
               {1'b0, 8'hC3, 3'b011}, {1'b0, 8'hC3, 3'b000} };
    apply_reset();
    start_i = 1'b1; len_i = 8'd3; s_valid_i = 1'b1; s_data_i = 8'hA1; tick(); start_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      act = {valid_o, number_o, run_o, busy_o, done_o};
      n_cmp++;
      if (act !== exp_t[k]) begin
        n_err++; $display("FAIL gaps_t%0d: got v/num/run/busy/done=%h expected %h", k, act, exp_t[k]);
      end
      s_valid_i = (k == 2 || k == 5);
      s_data_i  = (k == 2) ? 8'hB2 : 8'hC3;
      tick();
    end
`ifdef ACC_FEEDER_STALL_CNT_EN
    n_cmp++;
    if (stall_cnt_o !== 16'd4) begin n_err++; $display("FAIL gaps_stall: got %0d expected 4", stall_cnt_o); end
`endif
  endtask

  task automatic test_zero_len();
    logic [3:0] act, exp_v;
    apply_reset();
    start_i = 1'b1; len_i = 8'd0; tick(); start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      act   = {valid_o, run_o, busy_o, done_o};
      exp_v = (k == 0) ? 4'b0011 : 4'b0000;
      n_cmp++;
      if (act !== exp_v) begin
        n_err++; $display("FAIL zero_len_t%0d: got v/run/busy/done=%b expected %b", k, act, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic          rdy_prev, er;
    logic [DW-1:0] got [$];
    int            done_k;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'(10 + i); tick();
      er = (i < 3);
      n_cmp++;
      if (s_ready_o !== er) begin n_err++; $display("FAIL full_ready_push%0d: got %b expected %b", i + 1, s_ready_o, er); end
    end
    s_data_i = 8'd14;
    repeat (2) begin
      tick();
      n_cmp++;
      if (s_ready_o !== 1'b0) begin n_err++; $display("FAIL full_hold: got ready %b expected 0", s_ready_o); end
    end
    start_i = 1'b1; len_i = 8'd2; tick(); start_i = 1'b0;
    rdy_prev = 1'b0; done_k = -1;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      if (valid_o) got.push_back(number_o);
      if (done_o) done_k = k;
      if (s_valid_i && rdy_prev) s_valid_i = 1'b0;
      rdy_prev = s_ready_o;
      tick();
    end
    n_cmp++;
    if (got.size() != 2 || got[0] !== 8'd10 || got[1] !== 8'd11 || done_k != 3) begin
      n_err++; $display("FAIL full_frame: got %0d elems first=%0d done_t=%0d expected 2 elems 10,11 done_t=3",
                        got.size(), (got.size() > 0) ? got[0] : 8'd0, done_k);
    end
    n_cmp++;
    if (s_ready_o !== 1'b1 || s_valid_i !== 1'b0) begin
      n_err++; $display("FAIL full_left: got ready %b held_valid %b expected ready 1, 5th accepted", s_ready_o, s_valid_i);
    end
    got.delete(); done_k = -1;
    start_i = 1'b1; len_i = 8'd3; tick(); start_i = 1'b0;
    for (int k = 0; k < 20 && done_k < 0; k++) begin
      if (valid_o) got.push_back(number_o);
      if (done_o) done_k = k;
      tick();
    end
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'd12 || got[1] !== 8'd13 || got[2] !== 8'd14) begin
      n_err++; $display("FAIL full_remaining: got %0d elems expected 3 elems 12,13,14", got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] act;
    apply_reset();
    for (int i = 5; i <= 8; i++) begin s_valid_i = 1'b1; s_data_i = 8'(i); tick(); end
    s_valid_i = 1'b0; start_i = 1'b1; len_i = 8'd100; tick(); start_i = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    act = {number_o, valid_o, run_o, busy_o, done_o, s_ready_o};
    n_cmp++;
    if (act !== {8'h00, 5'b00001}) begin
      n_err++; $display("FAIL midreset_async: got num/v/run/busy/done/rdy=%h expected %h", act, {8'h00, 5'b00001});
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({valid_o, busy_o, done_o} !== 3'b000) begin
        n_err++; $display("FAIL midreset_after_t%0d: got v/busy/done=%b expected 000", k, {valid_o, busy_o, done_o});
      end
    end
    // Buffer must be empty: a 1-element frame stalls until a fresh push
    start_i = 1'b1; len_i = 8'd1; tick(); start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({valid_o, run_o} !== 2'b01) begin
        n_err++; $display("FAIL midreset_discard_t%0d: got v/run=%b expected 01", k, {valid_o, run_o});
      end
      tick();
    end
    s_valid_i = 1'b1; s_data_i = 8'h3C; tick(); s_valid_i = 1'b0; tick();
    n_cmp++;
    if ({valid_o, number_o, run_o} !== {1'b1, 8'h3C, 1'b1}) begin
      n_err++; $display("FAIL midreset_fresh: got v/num/run=%h expected %h", {valid_o, number_o, run_o}, {1'b1, 8'h3C, 1'b1});
    end
    tick();
    n_cmp++;
    if (done_o !== 1'b1) begin n_err++; $display("FAIL midreset_done: got %b expected 1", done_o); end
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] got [$];
    int            done_k;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin s_valid_i = 1'b1; s_data_i = 8'(i); tick(); end
    s_valid_i = 1'b0; start_i = 1'b1; len_i = 8'd3; tick(); start_i = 1'b0;
    done_k = -1;
    for (int k = 0; k < 7; k++) begin
      if (valid_o) got.push_back(number_o);
      if (done_o && done_k < 0) done_k = k;
      if (k >= 5) begin
        n_cmp++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL start_ign_busy_t%0d: got %b expected 0", k, busy_o); end
      end
      start_i = (k == 1 || k == 4);
      len_i   = (k == 1) ? 8'd1 : 8'd2;
      tick();
    end
    start_i = 1'b0;
    n_cmp++;
    if (got.size() != 3 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3 || done_k != 4) begin
      n_err++; $display("FAIL start_ign_frame: got %0d elems done_t=%0d expected 3 elems 1,2,3 done_t=4", got.size(), done_k);
    end
  endtask

  task automatic test_frame_random();
    int            len, nv, stall, prev_occ;
    bit            prev_inrun, fin;
    logic          exp_v, exp_run, exp_done;
    logic [DW-1:0] exp_n;
    apply_reset();
    for (int f = 0; f < 10; f++) begin
      len = $urandom_range(1, 12);
      repeat ($urandom_range(0, 5)) begin
        s_valid_i = 1'($urandom); s_data_i = 8'($urandom); tick();
      end
      start_i = 1'b1; len_i = 8'(len); s_valid_i = 1'($urandom); s_data_i = 8'($urandom); tick(); start_i = 1'b0;
      nv = 0; stall = 0; prev_inrun = 1'b0; prev_occ = 0; fin = 1'b0;
      for (int k = 0; k < 400 && !fin; k++) begin
        // An element appears iff the previous cycle was RUN with data buffered
        exp_v = prev_inrun && (prev_occ > 0);
        if (prev_inrun && prev_occ == 0) stall++;
        n_cmp++;
        if (valid_o !== exp_v) begin n_err++; $display("FAIL rnd_valid f%0d t%0d: got %b expected %b", f, k, valid_o, exp_v); end
        if (valid_o === 1'b1) begin
          nv++;
          n_cmp++;
          if (mq.size() == 0) begin
            n_err++; $display("FAIL rnd_data f%0d t%0d: got %0d expected nothing (model empty)", f, k, number_o);
          end else begin
            exp_n = mq.pop_front();
            if (number_o !== exp_n) begin n_err++; $display("FAIL rnd_data f%0d t%0d: got %0d expected %0d", f, k, number_o, exp_n); end
          end
        end
        exp_run  = (nv < len) || (valid_o === 1'b1 && nv == len);
        exp_done = (nv >= len) && !exp_run;
        n_cmp++;
        if ({run_o, busy_o, done_o} !== {exp_run, exp_run | exp_done, exp_done}) begin
          n_err++; $display("FAIL rnd_status f%0d t%0d: got run/busy/done=%b expected %b", f, k,
                            {run_o, busy_o, done_o}, {exp_run, exp_run | exp_done, exp_done});
        end
        n_cmp++;
        if (s_ready_o !== (mq.size() < DEPTH)) begin
          n_err++; $display("FAIL rnd_ready f%0d t%0d: got %b expected %b", f, k, s_ready_o, (mq.size() < DEPTH));
        end
        fin        = exp_done;
        prev_inrun = (nv < len);
        prev_occ   = mq.size();
        s_valid_i  = 1'($urandom); s_data_i = 8'($urandom);
        tick();
      end
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL rnd_timeout f%0d: got %0d of %0d elements, no done", f, nv, len); end
`ifdef ACC_FEEDER_STALL_CNT_EN
      n_cmp++;
      if (stall_cnt_o !== 16'(stall)) begin n_err++; $display("FAIL rnd_stall f%0d: got %0d expected %0d", f, stall_cnt_o, stall); end
`endif
    end
    s_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prebuffered();
    test_gaps();
    test_zero_len();
    test_full();
    test_reset_mid();
    test_start_ignored();
    test_frame_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish within 500000");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
